cv32e40p_voter_fault_mgr: RTL
=============================

# cv32e40p_voter_fault_mgr

Parametrised TMR voter with fault management, the next generation after the fixed-width ALU/compare/ready voters. It majority-votes three replica results of any width and counts consecutive disagreements per replica. A replica that persistently disagrees is retired, and the block degrades from TMR to duplex, or to failed. It sits between the triplicated ALUs and the EX stage and reports fault status to the core's debug/CSR logic.

## Interface
- WIDTH, 32: bits per replica result.
- THRESH, 4: consecutive mismatching votes that mark a replica permanently faulty; must be ≥1.
- CNT_W, $clog2(THRESH+1): mismatch counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  this cycle's replica results are a real vote and update fault state.
- res1_i, res2_i, res3_i  in  WIDTH each  replica results.
- clear_i  in  1  software clear: return to TMR and zero all fault state.
- result_o  out  WIDTH  voted/selected result; combinational.
- faulty_o  out  1  current cycle disagreement among active replicas; combinational.
- mismatch_o  out  3  per-replica disagreement with result_o this cycle; combinational.
- perm_fault_o  out  3  sticky "replica retired" flags; registered.
- mode_o  out  2  00 TMR, 01 DMR, 10 FAIL; registered.
- uncorr_o  out  1  sticky uncorrectable error; registered.

## Operation
- TMR mode:
  - result_o is the bitwise majority of the three replica results.
  - mismatch_o[k] = (res_k ≠ result_o).
  - faulty_o = |mismatch_o.
- Per-replica counter cnt[k], updated only when valid_i=1 and in TMR:
  - mismatch: cnt[k] increments, saturating at THRESH.
  - match: cnt[k] clears to 0.
  - Counting is consecutive, not cumulative.
- Retirement: when an update makes cnt[k] reach THRESH, perm_fault_o[k] sets and mode goes TMR→DMR.
- Simultaneous retirement: if two or more counters reach THRESH on the same update, mode goes TMR→FAIL, uncorr_o sets, and all reaching replicas are flagged.
- DMR mode:
  - Active pair is the two non-retired replicas.
  - result_o = the lower-index active replica.
  - mismatch_o bits of the active pair are set when the pair differs. The retired bit is 0.
  - faulty_o = pair disagreement.
  - A valid_i vote with pair disagreement moves DMR→FAIL and sets uncorr_o. It is immediate; no threshold applies.
  - Counters are frozen in DMR.
- FAIL mode:
  - result_o = the lower-index non-retired replica, or res1_i if none remain.
  - faulty_o = 1 and mismatch_o = 0.
  - Counters are frozen.
  - Only rst or clear_i exit FAIL.
- clear_i:
  - Next cycle: mode TMR, all cnt 0, perm_fault_o 0, uncorr_o 0.
  - clear_i has priority over a same-cycle vote update; that vote is discarded for state.
  - The combinational outputs for that cycle still reflect the pre-clear mode.
- valid_i=0: combinational outputs still computed, no state change.

## Timing
- result_o, faulty_o, mismatch_o: zero-latency combinational from res*_i and the current mode/retired register. There is no register in the data path.
- State update: mode_o, perm_fault_o, uncorr_o and counters change on the edge that samples the triggering valid_i vote. They are visible the following cycle.
- The vote that trips the threshold is already masked in result_o by the majority. The retired replica is excluded from the next cycle on.
- Reset: mode_o=00, perm_fault_o=000, uncorr_o=0, all cnt=0.
  - Combinational outputs immediately follow TMR behaviour.
  - rst overrides clear_i and valid_i.
  - rst during DMR/FAIL returns to TMR on the next cycle.
- A THRESH=1 retirement happens on the first mismatching vote.

## Structure
- Shared package cv32e40p_voter_pkg:
  - voter_mode_e enum (VOTE_TMR=2'b00, VOTE_DMR=2'b01, VOTE_FAIL=2'b10).
  - Default THRESH localparam.
- One natural sub-module: the existing cv32e40p_voter_generic. It is instantiated with WIDTH for the TMR majority path.
- Built in this block:
  - DMR selection.
  - Mismatch comparators.
  - The three saturating counters.
  - The mode FSM.

## Test plan
- Clean voting: WIDTH=32, all replicas 0xA5A5_0000, valid_i=1 for 10 cycles -> result_o=0xA5A5_0000, faulty_o=0, mode_o=00, all cnt 0.
- Transient fault: res2 differs 3 cycles (THRESH=4), then agrees -> result_o correct throughout, mismatch_o=010 for 3 cycles, no retirement, cnt[2] back to 0.
- Permanent fault: res3 = 0xDEAD_BEEF vs others 0x1 for 4 valid votes -> perm_fault_o=100 and mode_o=01 the cycle after the 4th vote, result_o=res1.
- DMR pair disagreement: after the previous test, res1=0x1, res2=0x2 with valid_i=1 -> next cycle mode_o=10, uncorr_o=1. Stays until clear_i. Then mode_o=00, flags 0.
- Simultaneous retirement: res1 and res3 each differ from res2 and from each other in distinct bits for THRESH votes -> mode_o=10, perm_fault_o=101, uncorr_o=1.
- Priority: clear_i and a tripping vote in the same cycle -> no retirement, mode_o=00. rst asserted in FAIL -> all registered outputs at reset values next cycle.

Source files
------------

// File: rtl/cv32e40p_voter_pkg.sv
// cv32e40p_voter_pkg: shared voter mode encoding and default mismatch threshold
package cv32e40p_voter_pkg;
  typedef enum logic [1:0] {
    VOTE_TMR  = 2'b00,
    VOTE_DMR  = 2'b01,
    VOTE_FAIL = 2'b10
  } voter_mode_e;
  localparam int VOTE_THRESH = 4;
endpackage

// File: rtl/cv32e40p_voter_generic.sv
// cv32e40p_voter_generic: bitwise 2-of-3 majority of three WIDTH-bit replica results
module cv32e40p_voter_generic #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  output logic [WIDTH-1:0] result_o
);
  assign result_o = (res1_i & res2_i) | (res1_i & res3_i) | (res2_i & res3_i);
endmodule

// File: rtl/cv32e40p_voter_fault_mgr.sv
// cv32e40p_voter_fault_mgr: TMR voter that retires persistently disagreeing replicas, degrading TMR->DMR->FAIL
module cv32e40p_voter_fault_mgr
  import cv32e40p_voter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int THRESH = VOTE_THRESH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] res1_i,
  input  logic [WIDTH-1:0] res2_i,
  input  logic [WIDTH-1:0] res3_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] result_o,
  output logic             faulty_o,
  output logic [2:0]       mismatch_o,
  output logic [2:0]       perm_fault_o,
  output logic [1:0]       mode_o,
  output logic             uncorr_o
);
  localparam int CNT_W = $clog2(THRESH + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(THRESH);
  voter_mode_e mode_q, mode_d;
  logic [2:0] perm_q, perm_d, mm_tmr, reach;
  logic unc_q, unc_d, pair_diff, tmr_upd;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [WIDTH-1:0] maj, sel;
  cv32e40p_voter_generic #(.WIDTH(WIDTH)) u_vote (
    .res1_i  (res1_i),
    .res2_i  (res2_i),
    .res3_i  (res3_i),
    .result_o(maj)
  );
  assign sel = !perm_q[0] ? res1_i : !perm_q[1] ? res2_i : !perm_q[2] ? res3_i : res1_i;
  assign pair_diff = (perm_q[0] ? res2_i : res1_i) != (perm_q[2] ? res2_i : res3_i);
  assign mm_tmr = {res3_i != maj, res2_i != maj, res1_i != maj};
  assign tmr_upd = valid_i && mode_q == VOTE_TMR;
  assign result_o = mode_q == VOTE_TMR ? maj : sel;
  assign mismatch_o = mode_q == VOTE_TMR ? mm_tmr : mode_q == VOTE_DMR && pair_diff ? ~perm_q : 3'b000;
  assign faulty_o = mode_q == VOTE_TMR ? |mm_tmr : mode_q == VOTE_DMR ? pair_diff : 1'b1;
  assign perm_fault_o = perm_q;
  assign mode_o = mode_q;
  assign uncorr_o = unc_q;
  always_comb begin
    mode_d = mode_q;
    perm_d = perm_q;
    unc_d = unc_q;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = cnt_q[k];
      if (tmr_upd) cnt_d[k] = mm_tmr[k] ? (cnt_q[k] == LIMIT ? LIMIT : cnt_q[k] + 1'b1) : '0;
      reach[k] = tmr_upd && cnt_d[k] == LIMIT;
    end
    if (|reach) begin
      perm_d = perm_q | reach;
      unc_d = (reach[0] & reach[1]) | (reach[0] & reach[2]) | (reach[1] & reach[2]);
      mode_d = unc_d ? VOTE_FAIL : VOTE_DMR;
    end
    if (valid_i && mode_q == VOTE_DMR && pair_diff) begin
      mode_d = VOTE_FAIL;
      unc_d = 1'b1;
    end
    if (clear_i) begin
      mode_d = VOTE_TMR;
      perm_d = '0;
      unc_d = 1'b0;
      for (int k = 0; k < 3; k++) cnt_d[k] = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= VOTE_TMR;
      perm_q <= '0;
      unc_q <= 1'b0;
      for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else begin
      mode_q <= mode_d;
      perm_q <= perm_d;
      unc_q <= unc_d;
      for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
    end
  end
endmodule
